mem_cache_ctrl: RTL and testbench

//  Direct-mapped, write-through, no-write-allocate data cache between the MEM stage and the SRAM controller.

---
 rtl/mem_cache_ctrl_if.sv | 37 +++
 rtl/mem_cache_ctrl.sv | 174 +++++++++++++++++
 tb/tb_mem_cache_ctrl.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_cache_ctrl_if.sv
// mem_cache_ctrl_if
//  Bundles the MEM-stage request handshake and the SRAM-controller word bus
//  that the data cache sits between.
//  Upstream (MEM side):   R_EN, W_EN, address, data_in -> cache; data_out, ready <- cache
//  Downstream (SRAM side): sram_R_EN, sram_W_EN, sram_address, sram_wdata <- cache;
//                          sram_rdata, sram_ready -> cache
//  modport slave  : the cache controller's view
//  modport master : the surrounding environment (MEM stage plus SRAM controller)
interface mem_cache_ctrl_if;
    logic        R_EN;
    logic        W_EN;
    logic [31:0] address;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        ready;

    logic        sram_R_EN;
    logic        sram_W_EN;
    logic [31:0] sram_address;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic        sram_ready;

    modport slave (
        input  R_EN, W_EN, address, data_in,
        output data_out, ready,
        output sram_R_EN, sram_W_EN, sram_address, sram_wdata,
        input  sram_rdata, sram_ready
    );

    modport master (
        output R_EN, W_EN, address, data_in,
        input  data_out, ready,
        input  sram_R_EN, sram_W_EN, sram_address, sram_wdata,
        output sram_rdata, sram_ready
    );
endinterface

// File: rtl/mem_cache_ctrl.sv
// mem_cache_ctrl
//  Direct-mapped, write-through, no-write-allocate data cache between the MEM
//  stage and the SRAM controller. Lines hold two 32-bit words. Read hits
//  complete combinationally in the request cycle; read misses refill the line
//  with two SRAM word reads; writes always go to SRAM and patch the cached
//  word when the line is present.
//  Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-low reset
//   bus  - mem_cache_ctrl_if.slave (MEM handshake + SRAM word bus)
//
//  state    | meaning
//  ---------+--------------------------------------------------------------
//  S_IDLE   | serve read hits, launch a refill or a write-through
//  S_RD0    | waiting for word0 of the line from SRAM
//  S_RD_GAP | one-cycle enable gap, then request word1
//  S_RD1    | waiting for word1; line is written and validated on completion
//  S_WR     | waiting for the SRAM write to complete
module mem_cache_ctrl #(
    parameter int SET_BITS = 6,
    parameter int ADDR_W   = 19
) (
    input  logic             clk,
    input  logic             rst,
    mem_cache_ctrl_if.slave  bus
);

    localparam int TAG_W = ADDR_W - SET_BITS - 3;
    localparam int LINES = 1 << SET_BITS;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RD0    = 3'd1;
    localparam logic [2:0] S_RD_GAP = 3'd2;
    localparam logic [2:0] S_RD1    = 3'd3;
    localparam logic [2:0] S_WR     = 3'd4;

    logic [2:0]          state_q;
    logic [LINES-1:0]    valid_q;
    logic [TAG_W-1:0]    tag_q   [LINES];
    logic [31:0]         word0_q [LINES];
    logic [31:0]         word1_q [LINES];
    logic [31:0]         fill_q;

    logic                sram_r_en_q;
    logic                sram_w_en_q;
    logic [31:0]         sram_addr_q;
    logic [31:0]         sram_wdata_q;

    logic [SET_BITS-1:0] req_idx;
    logic [TAG_W-1:0]    req_tag;
    logic                req_hit;
    logic [SET_BITS-1:0] line_idx;
    logic [TAG_W-1:0]    line_tag;
    logic                line_hit;
    logic                fill_we;
    logic                wr_we;
    logic                unused_addr_bits;

    assign unused_addr_bits = ^bus.address[1:0];

    // Lookup for the live request (IDLE only ever trusts this one).
    assign req_idx = bus.address[SET_BITS+2:3];
    assign req_tag = bus.address[ADDR_W-1:SET_BITS+3];
    assign req_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

    // Once out of IDLE, the line being worked on is identified by the
    // registered SRAM address, so the caller's address is not re-sampled.
    assign line_idx = sram_addr_q[SET_BITS+2:3];
    assign line_tag = sram_addr_q[ADDR_W-1:SET_BITS+3];
    assign line_hit = valid_q[line_idx] && (tag_q[line_idx] == line_tag);

    assign fill_we = rst && (state_q == S_RD1) && bus.sram_ready;
    assign wr_we   = rst && (state_q == S_WR) && bus.sram_ready && line_hit;

    always_comb begin
        bus.ready = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.W_EN) begin
                    bus.ready = 1'b0;
                end else if (bus.R_EN) begin
                    bus.ready = req_hit;
                end else begin
                    bus.ready = 1'b1;
                end
            end
            S_WR:    bus.ready = bus.sram_ready;
            default: bus.ready = 1'b0;
        endcase
    end

    always_comb begin
        bus.data_out = '0;
        if (req_hit) begin
            bus.data_out = bus.address[2] ? word1_q[req_idx] : word0_q[req_idx];
        end
    end

    assign bus.sram_R_EN    = sram_r_en_q;
    assign bus.sram_W_EN    = sram_w_en_q;
    assign bus.sram_address = sram_addr_q;
    assign bus.sram_wdata   = sram_wdata_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            valid_q      <= '0;
            sram_r_en_q  <= 1'b0;
            sram_w_en_q  <= 1'b0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // A simultaneous R_EN is ignored: the write wins.
                    if (bus.W_EN) begin
                        sram_addr_q  <= {bus.address[31:2], 2'b00};
                        sram_wdata_q <= bus.data_in;
                        sram_w_en_q  <= 1'b1;
                        state_q      <= S_WR;
                    end else if (bus.R_EN && !req_hit) begin
                        sram_addr_q  <= {bus.address[31:3], 3'b000};
                        sram_r_en_q  <= 1'b1;
                        state_q      <= S_RD0;
                    end
                end
                S_RD0: begin
                    if (bus.sram_ready) begin
                        sram_r_en_q <= 1'b0;
                        state_q     <= S_RD_GAP;
                    end
                end
                S_RD_GAP: begin
                    sram_addr_q <= {sram_addr_q[31:3], 3'b100};
                    sram_r_en_q <= 1'b1;
                    state_q     <= S_RD1;
                end
                S_RD1: begin
                    if (bus.sram_ready) begin
                        sram_r_en_q       <= 1'b0;
                        valid_q[line_idx] <= 1'b1;
                        state_q           <= S_IDLE;
                    end
                end
                S_WR: begin
                    if (bus.sram_ready) begin
                        sram_w_en_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Tag/data storage is deliberately not reset; only valid bits are.
    always_ff @(posedge clk) begin
        if ((state_q == S_RD0) && bus.sram_ready) begin
            fill_q <= bus.sram_rdata;
        end
        if (fill_we) begin
            tag_q[line_idx]   <= line_tag;
            word0_q[line_idx] <= fill_q;
            word1_q[line_idx] <= bus.sram_rdata;
        end else if (wr_we) begin
            if (sram_addr_q[2]) begin
                word1_q[line_idx] <= sram_wdata_q;
            end else begin
                word0_q[line_idx] <= sram_wdata_q;
            end
        end
    end

endmodule

// File: tb/tb_mem_cache_ctrl.sv
module tb_mem_cache_ctrl;

    localparam int NUM_SETS = 64;
    localparam int TAG_SPAN = 1024;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_cache_ctrl_if bus();

    mem_cache_ctrl #(.SET_BITS(6), .ADDR_W(19)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        int          lat;
    } sram_txn_t;

    sram_txn_t   sram_log[$];
    sram_txn_t   m_txn;
    logic [31:0] sram_mem [logic [31:0]];
    int          m_state = 0;
    int          m_cnt = 0;
    bit          m_wr;
    logic [31:0] m_addr, m_wdata;

    function automatic logic [31:0] init_word(input logic [31:0] wa);
        return (wa * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    // SRAM controller model: variable latency, one-cycle ready pulse, logs every request.
    always @(posedge clk) begin
        if (!rst) begin
            m_state <= 0;
            bus.sram_ready <= 1'b0;
        end else begin
            case (m_state)
                0: begin
                    bus.sram_ready <= 1'b0;
                    if (bus.sram_R_EN || bus.sram_W_EN) begin
                        m_txn.wr   = bus.sram_W_EN;
                        m_txn.addr = bus.sram_address;
                        m_txn.data = bus.sram_wdata;
                        m_txn.lat  = $urandom_range(0, 3);
                        sram_log.push_back(m_txn);
                        m_cnt   <= m_txn.lat;
                        m_wr    <= m_txn.wr;
                        m_addr  <= m_txn.addr;
                        m_wdata <= m_txn.data;
                        m_state <= 1;
                    end
                end
                1: begin
                    if (m_cnt == 0) begin
                        bus.sram_ready <= 1'b1;
                        if (m_wr) sram_mem[m_addr] = m_wdata;
                        else bus.sram_rdata <= sram_mem.exists(m_addr) ? sram_mem[m_addr] : init_word(m_addr);
                        m_state <= 2;
                    end else begin
                        m_cnt <= m_cnt - 1;
                    end
                end
                default: begin
                    bus.sram_ready <= 1'b0;
                    m_state <= 0;
                end
            endcase
        end
    end

    // Reference: which line holds which tag, plus the memory image.
    bit          ref_valid [NUM_SETS];
    int          ref_tag   [NUM_SETS];
    logic [31:0] ref_mem   [logic [31:0]];

    function automatic int set_of(input logic [31:0] a);
        return int'((a / 8) % NUM_SETS);
    endfunction

    function automatic int tag_of(input logic [31:0] a);
        return int'((a / 512) % TAG_SPAN);
    endfunction

    function automatic logic [31:0] word_addr(input logic [31:0] a);
        return (a / 4) * 4;
    endfunction

    function automatic bit ref_hit(input logic [31:0] a);
        return ref_valid[set_of(a)] && (ref_tag[set_of(a)] == tag_of(a));
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [31:0] wa;
        wa = word_addr(a);
        return ref_mem.exists(wa) ? ref_mem[wa] : init_word(wa);
    endfunction

    function automatic void ref_apply(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
        if (wr) begin
            ref_mem[word_addr(a)] = d;
        end else if (rd && !ref_hit(a)) begin
            ref_valid[set_of(a)] = 1'b1;
            ref_tag[set_of(a)]   = tag_of(a);
        end
    endfunction

    function automatic void ref_reset();
        for (int i = 0; i < NUM_SETS; i++) ref_valid[i] = 1'b0;
    endfunction

    // Request-to-ready cycles: each SRAM access spans (model latency + 3) cycles
    // from enable to ready pulse inclusive; a refill adds 2 more.
    function automatic int exp_miss_cycles();
        if (sram_log.size() != 2) return -1;
        return (sram_log[0].lat + 3) + (sram_log[1].lat + 3) + 2;
    endfunction

    function automatic int exp_write_cycles();
        if (sram_log.size() != 1) return -1;
        return sram_log[0].lat + 3;
    endfunction

    int          obs_cycles, obs_rises, obs_gap;
    bit          obs_timeout, obs_sram_ready;
    logic [31:0] obs_data;

    task automatic do_access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
        bit prev;
        @(negedge clk);
        bus.R_EN = rd;
        bus.W_EN = wr;
        bus.address = a;
        bus.data_in = d;
        sram_log.delete();
        obs_cycles = 0; obs_rises = 0; obs_gap = 0;
        obs_timeout = 1'b0; obs_sram_ready = 1'b0; obs_data = '0;
        prev = 1'b0;
        #1;
        while (1) begin
            if (bus.sram_R_EN && !prev) obs_rises++;
            if (!bus.sram_R_EN && obs_rises == 1) obs_gap++;
            prev = bus.sram_R_EN;
            if (bus.ready) begin
                obs_data = bus.data_out;
                obs_sram_ready = bus.sram_ready;
                break;
            end
            if (obs_cycles >= 60) begin
                obs_timeout = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
            obs_cycles++;
        end
        @(posedge clk);
    endtask

    task automatic go_idle();
        @(negedge clk);
        bus.R_EN = 1'b0;
        bus.W_EN = 1'b0;
    endtask

    task automatic test_reset();
        bus.R_EN = 1'b0; bus.W_EN = 1'b0; bus.address = '0; bus.data_in = '0;
        bus.sram_rdata = '0;
        rst = 1'b0;
        ref_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({bus.sram_R_EN, bus.sram_W_EN} !== 2'b00) begin
            n_bad++; $display("FAIL reset_en: got %b want 00", {bus.sram_R_EN, bus.sram_W_EN});
        end
        n_cmp++;
        if (bus.sram_address !== 32'h0 || bus.sram_wdata !== 32'h0) begin
            n_bad++; $display("FAIL reset_bus: got addr %h wdata %h want 0 0", bus.sram_address, bus.sram_wdata);
        end
        n_cmp++;
        if (bus.ready !== 1'b1 || bus.data_out !== 32'h0) begin
            n_bad++; $display("FAIL reset_out: got ready %b data %h want 1 0", bus.ready, bus.data_out);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_read_miss();
        do_access(1'b1, 1'b0, 32'h40, 32'h0);
        n_cmp++;
        if (sram_log.size() !== 2 || sram_log[0].addr !== 32'h40 || sram_log[1].addr !== 32'h44
            || sram_log[0].wr || sram_log[1].wr) begin
            n_bad++; $display("FAIL t1_traffic: got %0d txns want reads @40,@44", sram_log.size());
        end
        n_cmp++;
        if (obs_gap !== 1 || obs_rises !== 2) begin
            n_bad++; $display("FAIL t1_gap: got gap %0d rises %0d want 1 2", obs_gap, obs_rises);
        end
        n_cmp++;
        if (obs_timeout || obs_cycles !== exp_miss_cycles()) begin
            n_bad++; $display("FAIL t1_latency: got %0d want %0d", obs_cycles, exp_miss_cycles());
        end
        n_cmp++;
        if (obs_data !== init_word(32'h40)) begin
            n_bad++; $display("FAIL t1_data: got %h want %h", obs_data, init_word(32'h40));
        end
        ref_apply(1'b1, 1'b0, 32'h40, 32'h0);
    endtask

    task automatic test_read_hit();
        do_access(1'b1, 1'b0, 32'h44, 32'h0);
        n_cmp++;
        if (obs_cycles !== 0 || sram_log.size() !== 0) begin
            n_bad++; $display("FAIL t2_hit: got cycles %0d txns %0d want 0 0", obs_cycles, sram_log.size());
        end
        n_cmp++;
        if (obs_data !== init_word(32'h44)) begin
            n_bad++; $display("FAIL t2_data: got %h want %h", obs_data, init_word(32'h44));
        end
    endtask

    task automatic test_write_hit();
        do_access(1'b0, 1'b1, 32'h40, 32'hDEAD_BEEF);
        n_cmp++;
        if (sram_log.size() !== 1 || !sram_log[0].wr || sram_log[0].addr !== 32'h40
            || sram_log[0].data !== 32'hDEAD_BEEF) begin
            n_bad++; $display("FAIL t3_traffic: got %0d txns want one write DEADBEEF@40", sram_log.size());
        end
        n_cmp++;
        if (obs_timeout || !obs_sram_ready || obs_cycles !== exp_write_cycles()) begin
            n_bad++; $display("FAIL t3_ready: got cycles %0d sram_ready %b want %0d 1",
                              obs_cycles, obs_sram_ready, exp_write_cycles());
        end
        ref_apply(1'b0, 1'b1, 32'h40, 32'hDEAD_BEEF);
        do_access(1'b1, 1'b0, 32'h40, 32'h0);
        n_cmp++;
        if (obs_cycles !== 0 || sram_log.size() !== 0 || obs_data !== 32'hDEAD_BEEF) begin
            n_bad++; $display("FAIL t3_readback: got cycles %0d data %h want 0 DEADBEEF", obs_cycles, obs_data);
        end
    endtask

    task automatic test_write_miss();
        do_access(1'b0, 1'b1, 32'h200, 32'h1234_5678);
        n_cmp++;
        if (sram_log.size() !== 1 || !sram_log[0].wr || sram_log[0].addr !== 32'h200) begin
            n_bad++; $display("FAIL t4_write: got %0d txns want one write @200", sram_log.size());
        end
        ref_apply(1'b0, 1'b1, 32'h200, 32'h1234_5678);
        do_access(1'b1, 1'b0, 32'h200, 32'h0);
        n_cmp++;
        if (sram_log.size() !== 2 || obs_data !== 32'h1234_5678) begin
            n_bad++; $display("FAIL t4_refill: got %0d txns data %h want 2 12345678", sram_log.size(), obs_data);
        end
        ref_apply(1'b1, 1'b0, 32'h200, 32'h0);
    endtask

    task automatic test_conflict();
        do_access(1'b1, 1'b0, 32'h40, 32'h0);
        n_cmp++;
        if (sram_log.size() !== 0 || obs_data !== ref_word(32'h40)) begin
            n_bad++; $display("FAIL t5_first: got %0d txns data %h want 0 %h", sram_log.size(), obs_data, ref_word(32'h40));
        end
        do_access(1'b1, 1'b0, 32'h240, 32'h0);
        n_cmp++;
        if (sram_log.size() !== 2 || sram_log[0].addr !== 32'h240 || obs_data !== ref_word(32'h240)) begin
            n_bad++; $display("FAIL t5_replace: got %0d txns data %h want 2 %h", sram_log.size(), obs_data, ref_word(32'h240));
        end
        ref_apply(1'b1, 1'b0, 32'h240, 32'h0);
        do_access(1'b1, 1'b0, 32'h40, 32'h0);
        n_cmp++;
        if (sram_log.size() !== 2 || obs_data !== ref_word(32'h40)) begin
            n_bad++; $display("FAIL t5_evicted: got %0d txns data %h want 2 %h", sram_log.size(), obs_data, ref_word(32'h40));
        end
        ref_apply(1'b1, 1'b0, 32'h40, 32'h0);
    endtask

    task automatic test_reset_mid_fill();
        int rises;
        bit prev, found;
        @(negedge clk);
        bus.R_EN = 1'b1; bus.W_EN = 1'b0; bus.address = 32'h440;
        rises = 0; prev = 1'b0; found = 1'b0;
        for (int c = 0; c < 60; c++) begin
            #1;
            if (bus.sram_R_EN && !prev) rises++;
            prev = bus.sram_R_EN;
            if (rises == 2) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_cmp++;
        if (!found) begin
            n_bad++; $display("FAIL t6_reach_rd1: got %0d enable rises want 2", rises);
        end
        rst = 1'b0;
        bus.R_EN = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({bus.sram_R_EN, bus.sram_W_EN} !== 2'b00 || bus.sram_address !== 32'h0) begin
            n_bad++; $display("FAIL t6_drop: got en %b addr %h want 00 0", {bus.sram_R_EN, bus.sram_W_EN}, bus.sram_address);
        end
        n_cmp++;
        if (bus.ready !== 1'b1 || bus.data_out !== 32'h0) begin
            n_bad++; $display("FAIL t6_idle: got ready %b data %h want 1 0", bus.ready, bus.data_out);
        end
        @(negedge clk);
        rst = 1'b1;
        ref_reset();
        do_access(1'b1, 1'b0, 32'h40, 32'h0);
        n_cmp++;
        if (sram_log.size() !== 2 || obs_cycles !== exp_miss_cycles() || obs_data !== ref_word(32'h40)) begin
            n_bad++; $display("FAIL t6_cleared: got %0d txns cycles %0d data %h want 2 %0d %h",
                              sram_log.size(), obs_cycles, obs_data, exp_miss_cycles(), ref_word(32'h40));
        end
        ref_apply(1'b1, 1'b0, 32'h40, 32'h0);
    endtask

    task automatic test_both_enables();
        do_access(1'b1, 1'b0, 32'h48, 32'h0);
        ref_apply(1'b1, 1'b0, 32'h48, 32'h0);
        do_access(1'b1, 1'b1, 32'h4C, 32'hCAFE_F00D);
        n_cmp++;
        if (sram_log.size() !== 1 || !sram_log[0].wr || sram_log[0].addr !== 32'h4C) begin
            n_bad++; $display("FAIL both_write: got %0d txns want one write @4C", sram_log.size());
        end
        ref_apply(1'b0, 1'b1, 32'h4C, 32'hCAFE_F00D);
        do_access(1'b1, 1'b0, 32'h4C, 32'h0);
        n_cmp++;
        if (obs_cycles !== 0 || obs_data !== 32'hCAFE_F00D) begin
            n_bad++; $display("FAIL both_readback: got cycles %0d data %h want 0 CAFEF00D", obs_cycles, obs_data);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, d, exp_d;
        bit rd, wr, hit;
        int op, exp_cyc;
        for (int i = 0; i < 150; i++) begin
            a = ($urandom_range(0, 3) * 512) + ($urandom_range(6, 10) * 8)
                + ($urandom_range(0, 1) * 4) + $urandom_range(0, 3);
            d = $urandom;
            op = $urandom_range(0, 9);
            rd = (op <= 5) || (op == 9);
            wr = (op >= 6);
            hit = ref_hit(a);
            exp_d = ref_word(a);
            do_access(rd, wr, a, d);
            if (wr) begin
                exp_cyc = exp_write_cycles();
                n_cmp++;
                if (sram_log.size() !== 1 || !sram_log[0].wr || sram_log[0].addr !== word_addr(a)
                    || sram_log[0].data !== d) begin
                    n_bad++; $display("FAIL rnd_write[%0d]: @%h got %0d txns want one write of %h", i, a, sram_log.size(), d);
                end
                n_cmp++;
                if (obs_timeout || !obs_sram_ready || obs_cycles !== exp_cyc) begin
                    n_bad++; $display("FAIL rnd_wlat[%0d]: @%h got %0d want %0d", i, a, obs_cycles, exp_cyc);
                end
            end else if (hit) begin
                n_cmp++;
                if (obs_cycles !== 0 || sram_log.size() !== 0 || obs_data !== exp_d) begin
                    n_bad++; $display("FAIL rnd_hit[%0d]: @%h got cycles %0d txns %0d data %h want 0 0 %h",
                                      i, a, obs_cycles, sram_log.size(), obs_data, exp_d);
                end
            end else begin
                exp_cyc = exp_miss_cycles();
                n_cmp++;
                if (sram_log.size() !== 2 || sram_log[0].addr !== (a / 8) * 8
                    || sram_log[1].addr !== (a / 8) * 8 + 4 || obs_gap !== 1) begin
                    n_bad++; $display("FAIL rnd_fill[%0d]: @%h got %0d txns gap %0d want 2 1", i, a, sram_log.size(), obs_gap);
                end
                n_cmp++;
                if (obs_timeout || obs_cycles !== exp_cyc || obs_data !== exp_d) begin
                    n_bad++; $display("FAIL rnd_miss[%0d]: @%h got cycles %0d data %h want %0d %h",
                                      i, a, obs_cycles, obs_data, exp_cyc, exp_d);
                end
            end
            ref_apply(rd, wr, a, d);
        end
    endtask

    initial begin
        test_reset();
        test_read_miss();
        test_read_hit();
        test_write_hit();
        test_write_miss();
        test_conflict();
        test_reset_mid_fill();
        test_both_enables();
        test_random();
        go_idle();
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1, "time limit");
    end

endmodule
